ram_write_ctrl_fsm: RTL and testbench
=====================================

Name: ram_write_ctrl_fsm

Overview:
- Control state machine for a RAM-fill path.
- Waits for a start pulse from an upstream edge detector, then asserts the RAM write enable until the memory reports full, or until an internal write counter reaches the RAM depth.
- Then holds a full-memory indicator until reset.
- Sits between the edge detector / RAM address logic and the RAM write port.

Parameters:
- RAM_DEPTH, 1024: number of RAM words; maximum write-enable cycles per fill (must be >= 2).
- CNT_W, $clog2(RAM_DEPTH): width of the internal write counter (derived; not overridden).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- i_rst  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
- edge_detector  input  1  start request; level-sampled, one-cycle pulse expected from upstream edge detector.
- i_write_full  input  1  memory-full flag from RAM/address logic; level-sampled.
- o_write_ena  output  1  RAM write enable.
- full_mem_indicator  output  1  memory-full status flag.

Behaviour:
- Three states, binary encoded in a registered state register: IDLE, WRITE, FULL.
- Outputs are Moore, decoded from the registered state:
  - IDLE: o_write_ena=0, full_mem_indicator=0.
  - WRITE: o_write_ena=1, full_mem_indicator=0.
  - FULL: o_write_ena=0, full_mem_indicator=1.
- Reset: i_rst=0 at a rising edge sets state=IDLE and write counter=0. Both outputs are 0 from the following cycle.
  - Reset has priority over all other inputs in every state, including mid-WRITE.
- IDLE:
  - edge_detector=1 at an edge -> WRITE, counter cleared to 0.
  - i_write_full is ignored in IDLE.
  - Otherwise stay in IDLE.
- WRITE:
  - Counter increments by 1 every edge spent in WRITE.
  - i_write_full=1 at an edge -> FULL (highest non-reset priority).
  - Else if counter == RAM_DEPTH-1 -> FULL. Gives at most RAM_DEPTH write-enable cycles per fill.
  - edge_detector is ignored in WRITE.
  - Otherwise stay in WRITE.
- FULL:
  - Sticky; stays until reset.
  - edge_detector and i_write_full are ignored; counter holds.
- Latency:
  - o_write_ena rises in the cycle after the edge that samples edge_detector=1.
  - o_write_ena falls, and full_mem_indicator rises, in the cycle after the edge that samples i_write_full=1. Both change at the same edge.
- Simultaneous events:
  - i_write_full=1 and counter terminal on the same edge -> FULL (same result).
  - edge_detector and i_write_full both high in IDLE -> WRITE.
- Counter never wraps: it stops at RAM_DEPTH-1 because the state leaves WRITE.
- Unknown state encoding decodes to IDLE outputs and returns to IDLE on the next edge.

Test Plan:
- Hold i_rst=0 for 3 edges with random inputs -> o_write_ena=0, full_mem_indicator=0 throughout.
- Release reset; pulse edge_detector=1 for one cycle; i_write_full=0 -> o_write_ena=1 from the next cycle, full_mem_indicator=0.
- Continue the previous case; after 5 cycles raise i_write_full=1 -> next cycle o_write_ena=0, full_mem_indicator=1. Both remain so while edge_detector pulses again and i_write_full drops.
- RAM_DEPTH=8: start a write, keep i_write_full=0 -> o_write_ena high exactly 8 cycles, then full_mem_indicator=1.
- Mid-WRITE, drive i_rst=0 for one edge -> outputs 0 next cycle. With edge_detector=0 after reset, the FSM stays IDLE. A new edge_detector pulse restarts with a full RAM_DEPTH budget.
- In IDLE, drive i_write_full=1 without edge_detector -> remains IDLE, both outputs 0.

Source files
------------

// File: rtl/ram_write_ctrl_fsm_if.sv
// Handshake bundle between the start/full sources and the RAM-fill controller.
// The master drives the start and full requests; the slave drives the write enable and the full status.
interface ram_write_ctrl_fsm_if;
    logic edge_detector;
    logic i_write_full;
    logic o_write_ena;
    logic full_mem_indicator;

    modport master (
        output edge_detector,
        output i_write_full,
        input  o_write_ena,
        input  full_mem_indicator
    );

    modport slave (
        input  edge_detector,
        input  i_write_full,
        output o_write_ena,
        output full_mem_indicator
    );
endinterface

// File: rtl/ram_write_ctrl_fsm.sv
// RAM-fill control FSM: a start pulse opens a write burst, which closes on memory-full or after
// RAM_DEPTH enable cycles. The controller then holds the full indicator until reset.
module ram_write_ctrl_fsm #(
    parameter int RAM_DEPTH = 1024
) (
    input  logic               clk,
    input  logic               i_rst,
    ram_write_ctrl_fsm_if.slave bus
);
    localparam int CNT_W = $clog2(RAM_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAM_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WRITE = 2'b01,
        FULL  = 2'b10
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             write_ena;
    logic             full_ind;

    always_ff @(posedge clk) begin
        if (!i_rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        write_ena  = 1'b0;
        full_ind   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.edge_detector) begin
                    state_next = WRITE;
                    cnt_next   = '0;
                end
            end
            WRITE: begin
                write_ena = 1'b1;
                // The counter freezes on the exit edge, so it never wraps past the last word.
                if (bus.i_write_full || (cnt_reg == CNT_LAST)) begin
                    state_next = FULL;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            FULL: begin
                full_ind = 1'b1;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.o_write_ena        = write_ena;
    assign bus.full_mem_indicator = full_ind;
endmodule

// File: tb/tb_ram_write_ctrl_fsm.sv
// Self-checking bench for ram_write_ctrl_fsm: directed vector table, fill-budget sequences,
// and random traffic compared against a cycle-count reference model.
module tb_ram_write_ctrl_fsm;
    localparam int DEPTH = 8;

    logic clk;
    logic i_rst;
    int   total;
    int   bad;

    ram_write_ctrl_fsm_if bus ();

    ram_write_ctrl_fsm #(.RAM_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic rst;
        logic ed;
        logic wf;
        logic exp_we;
        logic exp_full;
    } vec_t;

    // Reference model: tracks whether a fill is in progress, how many enable cycles it has had,
    // and whether the memory has been declared full.
    bit m_filling;
    bit m_full;
    int m_writes;

    task automatic model_edge(input logic rst, input logic ed, input logic wf);
        if (!rst) begin
            m_filling = 0;
            m_full    = 0;
            m_writes  = 0;
        end else if (m_full) begin
            // sticky until reset
        end else if (m_filling) begin
            m_writes++;
            if (wf || m_writes == DEPTH) begin
                m_filling = 0;
                m_full    = 1;
            end
        end else if (ed) begin
            m_filling = 1;
            m_writes  = 0;
        end
    endtask

    task automatic check(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%b expected=%b at t=%0t", name, act, exp, $time);
        end
    endtask

    // Apply inputs, clock one edge, sample outputs 1 time unit later.
    task automatic step(input logic rst, input logic ed, input logic wf);
        i_rst             = rst;
        bus.edge_detector = ed;
        bus.i_write_full  = wf;
        @(posedge clk);
        #1;
    endtask

    // Starts a fill from IDLE and counts the enable cycles until the write enable drops.
    task automatic fill_run(input string name, input bit full_on_last);
        int cnt;
        int guard;
        step(1'b1, 1'b1, 1'b0);
        cnt   = 0;
        guard = 0;
        while (bus.o_write_ena === 1'b1 && guard < 4 * DEPTH) begin
            cnt++;
            guard++;
            step(1'b1, 1'b0, (full_on_last && cnt == DEPTH) ? 1'b1 : 1'b0);
        end
        $display("seq %s: enable cycles=%0d full=%b", name, cnt, bus.full_mem_indicator);
        check({name, "_enable_cycles"}, (cnt == DEPTH) ? 1'b1 : 1'b0, 1'b1);
        check({name, "_we_low"}, bus.o_write_ena, 1'b0);
        check({name, "_full"}, bus.full_mem_indicator, 1'b1);
    endtask

    vec_t vecs[21];

    initial begin
        total = 0;
        bad   = 0;
        i_rst             = 1'b0;
        bus.edge_detector = 1'b0;
        bus.i_write_full  = 1'b0;

        //            rst   ed    wf    we    full
        vecs[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[14] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[18] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[20] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 21; i++) begin
            step(vecs[i].rst, vecs[i].ed, vecs[i].wf);
            $display("vec %0d: rst=%b ed=%b wf=%b -> we=%b full=%b (exp %b %b)", i,
                     vecs[i].rst, vecs[i].ed, vecs[i].wf, bus.o_write_ena,
                     bus.full_mem_indicator, vecs[i].exp_we, vecs[i].exp_full);
            check($sformatf("vec%0d_we", i), bus.o_write_ena, vecs[i].exp_we);
            check($sformatf("vec%0d_full", i), bus.full_mem_indicator, vecs[i].exp_full);
        end

        // Full budget with no full flag, then terminal count coinciding with the full flag.
        step(1'b0, 1'b0, 1'b0);
        fill_run("budget", 1'b0);
        step(1'b0, 1'b0, 1'b0);
        fill_run("term_and_full", 1'b1);

        // Reset mid-fill, stay idle, then a new pulse gets the whole budget again.
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check("midwrite_we_before_rst", bus.o_write_ena, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        $display("seq midwrite_rst: we=%b full=%b", bus.o_write_ena, bus.full_mem_indicator);
        check("midwrite_rst_we", bus.o_write_ena, 1'b0);
        check("midwrite_rst_full", bus.full_mem_indicator, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0);
            check("post_rst_idle_we", bus.o_write_ena, 1'b0);
        end
        fill_run("restart", 1'b0);

        // Random traffic against the reference model.
        step(1'b0, 1'b0, 1'b0);
        model_edge(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2000; i++) begin
            logic r_rst;
            logic r_ed;
            logic r_wf;
            r_rst = ($urandom_range(0, 59) != 0);
            r_ed  = ($urandom_range(0, 7) == 0);
            r_wf  = ($urandom_range(0, 24) == 0);
            step(r_rst, r_ed, r_wf);
            model_edge(r_rst, r_ed, r_wf);
            $display("rand %0d: rst=%b ed=%b wf=%b -> we=%b full=%b (exp %b %b)", i, r_rst,
                     r_ed, r_wf, bus.o_write_ena, bus.full_mem_indicator, m_filling, m_full);
            check("rand_we", bus.o_write_ena, m_filling);
            check("rand_full", bus.full_mem_indicator, m_full);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
